// File: rtl/alu_entry_if.sv
// Switch/key inputs and display/flag outputs of the operand-entry ALU stage.
// The board side is the master; the ALU stage is the slave.
interface alu_entry_if;
  logic [3:0] sw;
  logic [1:0] op;
  logic       key_n;
  logic [3:0] aluout;
  logic       carry;
  logic       zero;
  logic       valid;
  logic [1:0] state;

  modport master (
    output sw, op, key_n,
    input  aluout, carry, zero, valid, state
  );

  modport slave (
    input  sw, op, key_n,
    output aluout, carry, zero, valid, state
  );
endinterface

// File: rtl/alu_entry.sv
// Operand-entry ALU stage: debounced key steps through A, B and opcode capture,
// then holds the computed result and flags for the seven-segment display.
module alu_entry #(
  parameter int DEBOUNCE = 500000
) (
  input  logic        clk,
  input  logic        rst,
  alu_entry_if.slave  bus
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RES = 2'd3
  } state_t;

  logic          s1_r;
  logic          s2_r;
  logic          pressed_s;
  logic          stable_r;
  logic          stable_d_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  state_t        state_r;
  logic [3:0]    a_r;
  logic [3:0]    b_r;
  logic [3:0]    aluout_r;
  logic          carry_r;
  logic          zero_r;
  logic          valid_r;
  logic [5:0]    res_s;

  // Returns {carry, zero, result[3:0]}; SUB carry is the borrow (a < b).
  function automatic logic [5:0] alu_calc(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic [1:0] o);
    logic [4:0] r;
    logic       c;
    case (o)
      2'b00: begin r = {1'b0, a} + {1'b0, b}; c = r[4];   end
      2'b01: begin r = {1'b0, a - b};         c = (a < b); end
      2'b10: begin r = {1'b0, a & b};         c = 1'b0;    end
      2'b11: begin r = {1'b0, a ^ b};         c = 1'b0;    end
      default: begin r = 5'd0;                c = 1'b0;    end
    endcase
    return {c, (r[3:0] == 4'd0), r[3:0]};
  endfunction

  assign pressed_s = ~s2_r;
  assign res_s     = alu_calc(a_r, b_r, bus.op);

  // Key synchronizer, level debouncer and one-cycle press pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r       <= 1'b1;
      s2_r       <= 1'b1;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      press_r    <= 1'b0;
    end else begin
      s1_r       <= bus.key_n;
      s2_r       <= s1_r;
      stable_d_r <= stable_r;
      press_r    <= stable_r & ~stable_d_r;
      if (pressed_s == stable_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= pressed_s;
        cnt_r    <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Entry sequencer with registered display value and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_A;
      a_r      <= 4'd0;
      b_r      <= 4'd0;
      aluout_r <= 4'd0;
      carry_r  <= 1'b0;
      zero_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        S_A: begin
          aluout_r <= bus.sw;
          if (press_r) begin
            a_r     <= bus.sw;
            state_r <= S_B;
          end else begin
            state_r <= S_A;
          end
        end
        S_B: begin
          aluout_r <= bus.sw;
          if (press_r) begin
            b_r     <= bus.sw;
            state_r <= S_OP;
          end else begin
            state_r <= S_B;
          end
        end
        S_OP: begin
          if (press_r) begin
            carry_r  <= res_s[5];
            zero_r   <= res_s[4];
            aluout_r <= res_s[3:0];
            valid_r  <= 1'b1;
            state_r  <= S_RES;
          end else begin
            aluout_r <= {2'b00, bus.op};
            state_r  <= S_OP;
          end
        end
        S_RES: begin
          // Leaving the result clears the flags on the same edge.
          if (press_r) begin
            valid_r <= 1'b0;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            state_r <= S_A;
          end else begin
            state_r <= S_RES;
          end
        end
        default: begin
          state_r <= S_A;
        end
      endcase
    end
  end

  assign bus.aluout = aluout_r;
  assign bus.carry  = carry_r;
  assign bus.zero   = zero_r;
  assign bus.valid  = valid_r;
  assign bus.state  = state_r;

endmodule
